// File: rtl/uart_cmd_interface.sv
// Byte-oriented command decoder between the UART receiver and transmitter: WRITE assembles
// a little-endian word, READ streams a word out LSB byte first. Optional XOR checksum: UART_CMD_CHECKSUM_EN.
module uart_cmd_interface #(
  parameter int                 NB_DATA        = 8,
  parameter int                 NB_WORD        = 32,
  parameter int                 TIMEOUT_CYCLES = 1_000_000,
  parameter logic [NB_DATA-1:0] CMD_WRITE      = 8'h01,
  parameter logic [NB_DATA-1:0] CMD_READ       = 8'h02
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_WORD-1:0] i_rd_word,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_WORD-1:0] o_word,
  output logic               o_word_valid,
  output logic               o_busy,
  output logic               o_error
);

  localparam int NBYTES = NB_WORD / NB_DATA;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_CMD_CHECKSUM_EN
  localparam int NXFER  = NBYTES + 1;
`else
  localparam int NXFER  = NBYTES;
`endif
  localparam logic [CW-1:0] LAST_BYTE = CW'(NXFER - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RX_PAYLOAD, WORD_OUT, TX_LOAD, TX_WAIT} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, idx;
  logic [TW-1:0]        tmr;
  logic [NB_WORD-1:0]   rx_shift, rx_next, rd_q, word_q;
  logic [NB_DATA-1:0]   tx_byte;
  logic                 err_q, err_n;
  logic                 cnt_clr, store_byte, tmr_clr, tmr_inc, load_rd, idx_inc, word_load;
`ifdef UART_CMD_CHECKSUM_EN
  logic [NB_DATA-1:0]   csum_rx, csum_tx;
`endif

  always_comb begin
    rx_next = rx_shift;
    for (int unsigned i = 0; i < NBYTES; i++)
      if (cnt == CW'(i)) rx_next[i*NB_DATA +: NB_DATA] = i_rx_data;
  end

  always_comb begin
    tx_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      if (idx == CW'(i)) tx_byte = rd_q[i*NB_DATA +: NB_DATA];
`ifdef UART_CMD_CHECKSUM_EN
    csum_tx = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      csum_tx = csum_tx ^ rd_q[i*NB_DATA +: NB_DATA];
    if (idx == CW'(NBYTES)) tx_byte = csum_tx;
`endif
  end

  always_comb begin
    state_n    = state;
    err_n      = 1'b0;
    cnt_clr    = 1'b0;
    store_byte = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    load_rd    = 1'b0;
    idx_inc    = 1'b0;
    word_load  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_WRITE) begin
            state_n = RX_PAYLOAD;
            cnt_clr = 1'b1;
            tmr_clr = 1'b1;
          end else if (i_rx_data == CMD_READ) begin
            state_n = TX_LOAD;
            load_rd = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RX_PAYLOAD: begin
        if (i_rx_done) begin
          store_byte = 1'b1;
          tmr_clr    = 1'b1;
          if (cnt == LAST_BYTE) begin
`ifdef UART_CMD_CHECKSUM_EN
            // the trailing byte is compared, not stored: all lanes are already filled
            if (i_rx_data == csum_rx) begin
              state_n   = WORD_OUT;
              word_load = 1'b1;
            end else begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
`else
            state_n   = WORD_OUT;
            word_load = 1'b1;
`endif
          end
        end else if (tmr == TO_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      WORD_OUT: begin
        state_n = IDLE;
        err_n   = i_rx_done;
      end
      TX_LOAD: begin
        state_n = TX_WAIT;
        err_n   = i_rx_done;
      end
      TX_WAIT: begin
        err_n = i_rx_done;
        if (i_tx_done) begin
          if (idx == LAST_BYTE) begin
            state_n = IDLE;
          end else begin
            state_n = TX_LOAD;
            idx_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      cnt      <= '0;
      idx      <= '0;
      tmr      <= '0;
      rx_shift <= '0;
      rd_q     <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_rx  <= '0;
`endif
    end else begin
      err_q <= err_n;
      if (cnt_clr) begin
        cnt      <= '0;
        rx_shift <= '0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_rx  <= '0;
`endif
      end else if (store_byte) begin
        cnt      <= cnt + 1'b1;
        rx_shift <= rx_next;
`ifdef UART_CMD_CHECKSUM_EN
        csum_rx  <= csum_rx ^ i_rx_data;
`endif
      end
      if (tmr_clr)      tmr <= '0;
      else if (tmr_inc) tmr <= tmr + 1'b1;
      if (load_rd) begin
        rd_q <= i_rd_word;
        idx  <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (word_load) word_q <= rx_next;
    end
  end

  assign o_tx_start   = (state == TX_LOAD);
  assign o_tx_data    = tx_byte;
  assign o_word       = word_q;
  assign o_word_valid = (state == WORD_OUT);
  assign o_busy       = (state != IDLE);
  assign o_error      = err_q;

endmodule

// File: doc/uart_cmd_interface.md
Name: uart_cmd_interface

Overview:
- Sits directly downstream of the UART core's receiver and directly upstream of its transmitter.
- Consumes received bytes and decodes a byte-oriented command protocol.
- WRITE: assembles NB_WORD-bit words from payload bytes and presents them to the processor/debug side.
- READ: serialises an NB_WORD-bit read word back out through the transmitter, LSB byte first.

Parameters:
- NB_DATA, 8, UART byte width.
- NB_WORD, 32, word width. Must be a multiple of NB_DATA; NBYTES = NB_WORD/NB_DATA.
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between payload bytes before abort.
- CMD_WRITE, 8'h01, write-command opcode.
- CMD_READ, 8'h02, read-command opcode.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  one-cycle pulse: a received byte is valid on i_rx_data.
- i_rx_data  in  NB_DATA  received byte.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- i_rd_word  in  NB_WORD  word to return on READ.
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data.
- o_tx_data  out  NB_DATA  byte to transmit, held stable until i_tx_done.
- o_word  out  NB_WORD  assembled write word.
- o_word_valid  out  1  one-cycle pulse: o_word is valid.
- o_busy  out  1  high in every state except IDLE.
- o_error  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Clock and reset: all state changes on the rising edge of clk. i_reset is synchronous and active-high.
- Reset values: state=IDLE, byte counter=0, timeout counter=0, shift registers=0, all outputs 0.
- IDLE:
  - i_rx_done with i_rx_data==CMD_WRITE -> RX_PAYLOAD, byte count=0.
  - i_rx_done with i_rx_data==CMD_READ -> latch i_rd_word on that edge -> TX_LOAD, byte index=0.
  - Any other opcode: stay in IDLE, pulse o_error next cycle.
- RX_PAYLOAD:
  - Each i_rx_done stores i_rx_data into byte lane [count]; the first payload byte is the LSB (little-endian).
  - When the NBYTES-th byte arrives -> WORD_OUT.
  - Timeout counter resets on every accepted byte and increments on every other cycle.
  - Counter reaching TIMEOUT_CYCLES-1 -> return to IDLE, discard partial word, pulse o_error, no o_word_valid.
- WORD_OUT: one cycle with o_word_valid=1 and o_word=assembled word, then IDLE. Latency from the last payload i_rx_done to o_word_valid is 1 cycle. o_word holds its value until the next WORD_OUT.
- TX_LOAD: o_tx_data = latched byte [index], o_tx_start=1 for exactly one cycle -> TX_WAIT.
- TX_WAIT:
  - Hold o_tx_data.
  - On i_tx_done: if index==NBYTES-1 -> IDLE; else index+1 -> TX_LOAD.
  - i_tx_done in IDLE, RX_PAYLOAD or WORD_OUT is ignored.
- Overrun: i_rx_done during TX_LOAD, TX_WAIT or WORD_OUT -> byte dropped, o_error pulsed, state unaffected.
- Gap: a new command arriving on the cycle the block re-enters IDLE is decoded normally; no dead cycle is required beyond WORD_OUT.
- Reset mid-operation: immediate return to IDLE on the next edge. A partial word is lost and no further o_tx_start is issued.
- Width rules: byte index and byte count are sized $clog2(NBYTES+1); timeout counter is sized $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined:
  - WRITE takes one extra byte after the payload: the XOR of all NBYTES payload bytes.
  - RX_PAYLOAD accepts NBYTES+1 bytes.
  - On a match -> WORD_OUT as normal.
  - On a mismatch -> o_error pulse, no o_word_valid, return to IDLE.
  - READ appends an (NBYTES+1)-th transmitted byte: the XOR of the NBYTES word bytes.
- Undefined: no checksum byte in either direction; behaviour as described above.

Test Plan:
- Reset, then send bytes 01,EF,BE,AD,DE -> one cycle after the last i_rx_done: o_word_valid=1, o_word=32'hDEADBEEF; o_busy=0 the following cycle.
- i_rd_word=32'h12345678, send 02, answer each o_tx_start with i_tx_done 10 cycles later -> o_tx_data sequence 78,56,34,12, exactly 4 o_tx_start pulses, then IDLE.
- TIMEOUT_CYCLES=16, send 01,AA,BB then silence -> o_error pulse 16 cycles after byte BB, no o_word_valid; a following 01,11,22,33,44 yields o_word=32'h44332211.
- Send opcode 7F -> one o_error pulse, state stays IDLE, no tx activity; an i_rx_done during an active READ transmission -> o_error pulse, transmitted bytes unchanged.
- Assert i_reset after 2 of 4 READ bytes have been sent -> no further o_tx_start, all outputs 0; a following 01 + 4 bytes works normally.
- With UART_CMD_CHECKSUM_EN: 01,01,02,03,04,04 -> o_word=32'h04030201 valid. With a checksum byte of 05 -> o_error, no o_word_valid. READ of 32'h04030201 transmits 01,02,03,04,04.
